qos_traffic_seq: RTL and testbench

- Synthesizable, parametrised successor of the QoS PCIe stimulus bench. Runs one scripted test pass: configure thresholds, push a burst, wait, drain the output FIFOs, then read the counters.
- Compares the behavioural and synthesized DUT copies every cycle and reports mismatches.
- Sits beside the two QoS DUT instances; replaces hand-written stimulus for regressions.

---
 rtl/qos_traffic_seq.sv | 128 ++++++++++++
 tb/tb_qos_traffic_seq.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/qos_traffic_seq.sv
// qos_traffic_seq: scripted QoS stimulus pass with cycle-by-cycle cross-check of two DUT copies.
// Define QOS_SEQ_LFSR_PAYLOAD_EN to draw the pushed payload from a Fibonacci LFSR instead of seed + k.
module qos_traffic_seq #(
  parameter int DATA_W = 12,
  parameter int NUM_CH = 4,
  parameter int SEL_W  = 2,
  parameter int CNT_W  = 8,
  parameter int IDX_W  = 3,
  parameter int LEN_W  = 8,
  parameter int UMB_W  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [LEN_W-1:0]         cfg_burst_len,
  input  logic [LEN_W-1:0]         cfg_wait,
  input  logic [LEN_W-1:0]         cfg_pop_len,
  input  logic [UMB_W-1:0]         cfg_umbral_high,
  input  logic [UMB_W-1:0]         cfg_umbral_low,
  input  logic [DATA_W-SEL_W-1:0]  cfg_seed,
  output logic                     push,
  output logic [DATA_W-1:0]        data_in,
  output logic [NUM_CH-1:0]        pop,
  output logic                     init,
  output logic [UMB_W-1:0]         umbralHigh,
  output logic [UMB_W-1:0]         umbralLow,
  output logic                     req,
  output logic [IDX_W-1:0]         idx,
  input  logic                     valid,
  input  logic                     valid_sint,
  input  logic [CNT_W-1:0]         data,
  input  logic [CNT_W-1:0]         data_sint,
  input  logic                     active_out,
  input  logic                     active_out_sint,
  input  logic                     idle_out,
  input  logic                     idle_out_sint,
  input  logic [NUM_CH*DATA_W-1:0] fifo_dout,
  input  logic [NUM_CH*DATA_W-1:0] fifo_dout_sint,
  output logic                     busy,
  output logic                     done,
  output logic                     mismatch,
  output logic [7:0]               mismatch_cnt
);
  localparam int PW = DATA_W - SEL_W;
  localparam logic [LEN_W-1:0] ONE = LEN_W'(1);
  typedef enum logic [2:0] {IDLE, CONFIG, PUSH, WAIT, DRAIN, READ, DONE} state_t;
  state_t state, nxt, to_wait, to_drain;
  logic [LEN_W-1:0] cnt, nxt_cnt, burst_q, wait_q, pop_q;
  logic [PW-1:0] seed_q, pay;
  logic take, mis, init_d, push_d, req_d, done_d, busy_d;
  logic [DATA_W-1:0] data_d;
  logic [NUM_CH-1:0] pop_d;
  logic [IDX_W-1:0] idx_d;
  assign take = state == IDLE && start;
  assign to_drain = pop_q != '0 ? DRAIN : READ;
  assign to_wait = wait_q != '0 ? WAIT : to_drain;
  assign mis = (fifo_dout != fifo_dout_sint) | (valid != valid_sint) | (active_out != active_out_sint)
             | (idle_out != idle_out_sint) | (valid & (data != data_sint));
`ifdef QOS_SEQ_LFSR_PAYLOAD_EN
  function automatic logic [31:0] taps(input int w);
    case (w)
      4:       taps = 32'h00c;
      5:       taps = 32'h014;
      6:       taps = 32'h030;
      7:       taps = 32'h060;
      8:       taps = 32'h0b8;
      9:       taps = 32'h110;
      10:      taps = 32'h240;
      11:      taps = 32'h500;
      12:      taps = 32'h829;
      default: taps = 32'd3 << (w - 2);
    endcase
  endfunction
  localparam logic [PW-1:0] TAPS = PW'(taps(PW));
  logic [PW-1:0] lfsr;
  // lfsr holds the previously pushed payload; outside PUSH it tracks the (nonzero) seed
  always_ff @(posedge clk) lfsr <= pay;
  assign pay = state == PUSH ? {lfsr[PW-2:0], ^(lfsr & TAPS)} : (seed_q == '0 ? PW'(1) : seed_q);
`else
  assign pay = seed_q + PW'(nxt_cnt);
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      {burst_q, wait_q, pop_q, seed_q} <= '0;
      {push, data_in, pop, init, req, idx, busy, done} <= '0;
      {umbralHigh, umbralLow, mismatch, mismatch_cnt} <= '0;
    end else begin
      state <= nxt;
      cnt <= nxt_cnt;
      {push, data_in, pop, init, req, idx, busy, done} <= {push_d, data_d, pop_d, init_d, req_d, idx_d, busy_d, done_d};
      if (take) begin
        {burst_q, wait_q, pop_q, seed_q} <= {cfg_burst_len, cfg_wait, cfg_pop_len, cfg_seed};
        {umbralHigh, umbralLow} <= {cfg_umbral_high, cfg_umbral_low};
        mismatch <= 1'b0;
        mismatch_cnt <= '0;
      end else if (busy && mis) begin
        mismatch <= 1'b1;
        mismatch_cnt <= mismatch_cnt + {7'd0, mismatch_cnt != 8'hff};
      end
    end
  end
  // zero-length phases fall through to the next non-empty phase without spending a cycle
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = start ? CONFIG : IDLE;
      CONFIG:  nxt = cnt[0] ? (burst_q != '0 ? PUSH : to_wait) : CONFIG;
      PUSH:    nxt = cnt == burst_q - ONE ? to_wait : PUSH;
      WAIT:    nxt = cnt == wait_q - ONE ? to_drain : WAIT;
      DRAIN:   nxt = cnt == pop_q - ONE ? READ : DRAIN;
      READ:    nxt = cnt == LEN_W'(NUM_CH) ? DONE : READ;
      default: nxt = IDLE;
    endcase
    nxt_cnt = nxt != state ? '0 : (cnt == '1 ? cnt : cnt + ONE);
  end
  always_comb begin
    init_d = nxt == CONFIG && nxt_cnt == '0;
    push_d = nxt == PUSH;
    data_d = push_d ? {nxt_cnt[SEL_W-1:0], pay} : '0;
    pop_d = nxt == DRAIN ? '1 : '0;
    req_d = nxt == READ;
    idx_d = req_d ? IDX_W'(nxt_cnt) : '0;
    done_d = nxt == DONE;
    busy_d = nxt != IDLE;
  end
endmodule

// File: tb/tb_qos_traffic_seq.sv
// tb_qos_traffic_seq: directed stimulus with hand-computed expectations for qos_traffic_seq.
module tb_qos_traffic_seq;
  logic clk = 0, reset = 1, start = 0;
  logic [7:0] cfg_burst_len = 0, cfg_wait = 0, cfg_pop_len = 0;
  logic [3:0] cfg_umbral_high = 0, cfg_umbral_low = 0;
  logic [9:0] cfg_seed = 0;
  logic push, init, req, busy, done, mismatch;
  logic [11:0] data_in;
  logic [3:0] pop, umbralHigh, umbralLow;
  logic [2:0] idx;
  logic [7:0] mismatch_cnt;
  logic valid = 0, valid_sint = 0, active_out = 0, active_out_sint = 0, idle_out = 0, idle_out_sint = 0;
  logic [7:0] data = 0, data_sint = 0;
  logic [47:0] fifo_dout = 0, fifo_dout_sint = 0;
  int checks = 0, errors = 0, busy_cycles;
  logic [11:0] exp_words [8] = '{12'h0FF, 12'h500, 12'h901, 12'hD02, 12'h103, 12'h504, 12'h905, 12'hD06};

  qos_traffic_seq dut (
    .clk(clk), .reset(reset), .start(start),
    .cfg_burst_len(cfg_burst_len), .cfg_wait(cfg_wait), .cfg_pop_len(cfg_pop_len),
    .cfg_umbral_high(cfg_umbral_high), .cfg_umbral_low(cfg_umbral_low), .cfg_seed(cfg_seed),
    .push(push), .data_in(data_in), .pop(pop), .init(init),
    .umbralHigh(umbralHigh), .umbralLow(umbralLow), .req(req), .idx(idx),
    .valid(valid), .valid_sint(valid_sint), .data(data), .data_sint(data_sint),
    .active_out(active_out), .active_out_sint(active_out_sint),
    .idle_out(idle_out), .idle_out_sint(idle_out_sint),
    .fifo_dout(fifo_dout), .fifo_dout_sint(fifo_dout_sint),
    .busy(busy), .done(done), .mismatch(mismatch), .mismatch_cnt(mismatch_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    repeat (3) tick();
    check("rst_push", push, 0);
    check("rst_data", data_in, 0);
    check("rst_pop", pop, 0);
    check("rst_init", init, 0);
    check("rst_umb", {umbralHigh, umbralLow}, 0);
    check("rst_req", {req, idx}, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_mis", {mismatch, mismatch_cnt}, 0);
    reset = 0;
    tick();
    check("idle_busy", busy, 0);
    cfg_burst_len = 8; cfg_wait = 20; cfg_pop_len = 2;
    cfg_umbral_high = 5; cfg_umbral_low = 1; cfg_seed = 10'h0FF;
    start = 1;
    tick();
    start = 0;
    check("cfg1_init", init, 1);
    check("cfg1_high", umbralHigh, 5);
    check("cfg1_low", umbralLow, 1);
    check("cfg1_busy", busy, 1);
    tick();
    check("cfg2_init", init, 0);
    check("cfg2_push", push, 0);
    for (int k = 0; k < 8; k++) begin
      tick();
      check($sformatf("push%0d", k), push, 1);
      check($sformatf("word%0d", k), data_in, exp_words[k]);
    end
    tick();
    check("wait_push", push, 0);
    check("wait_data", data_in, 0);
    check("umb_hold", {umbralHigh, umbralLow}, {4'd5, 4'd1});
    fifo_dout_sint[2*12 +: 12] = 12'hABC;
    repeat (3) tick();
    fifo_dout_sint = 0;
    check("mis_flag", mismatch, 1);
    check("mis_cnt", mismatch_cnt, 3);
    for (int i = 0; i < 16; i++) begin
      tick();
      check("wait_pop", pop, 0);
    end
    check("wait_mis_cnt", mismatch_cnt, 3);
    tick();
    check("drain1_pop", pop, 4'b1111);
    tick();
    check("drain2_pop", pop, 4'b1111);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("read_pop", pop, 0);
      check($sformatf("read%0d", i), {req, idx}, {1'b1, 3'(i)});
      check("read_done", done, 0);
    end
    tick();
    check("done_pulse", done, 1);
    check("done_req", {req, idx}, 0);
    check("done_busy", busy, 1);
    tick();
    check("post_done", done, 0);
    check("post_busy", busy, 0);
    check("post_mis", {mismatch, mismatch_cnt}, {1'b1, 8'd3});
    start = 1;
    tick();
    start = 0;
    check("clr_mis", {mismatch, mismatch_cnt}, 0);
    repeat (5) tick();
    check("abort_word3", data_in, 12'hD02);
    reset = 1;
    tick();
    reset = 0;
    check("abort_push", push, 0);
    check("abort_busy", busy, 0);
    tick();
    check("abort_done", done, 0);
    check("abort_idle", busy, 0);
    start = 1;
    tick();
    start = 0;
    tick();
    tick();
    check("restart_word0", {push, data_in}, {1'b1, 12'h0FF});
    tick();
    check("restart_word1", data_in, 12'h500);
    reset = 1;
    tick();
    reset = 0;
    cfg_burst_len = 0; cfg_wait = 0; cfg_pop_len = 0;
    start = 1;
    tick();
    start = 0;
    busy_cycles = 0;
    check("e_init", init, 1);
    if (busy) busy_cycles++;
    tick();
    if (busy) busy_cycles++;
    check("e_cfg2", {init, push, pop}, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      if (busy) busy_cycles++;
      check($sformatf("e_read%0d", i), {req, idx, push, pop}, {1'b1, 3'(i), 1'b0, 4'b0});
      start = i == 1;
    end
    start = 0;
    tick();
    if (busy) busy_cycles++;
    check("e_done", done, 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      if (busy) busy_cycles++;
    end
    check("e_busy_cycles", busy_cycles, 8);
    check("e_ignored_start", {busy, done, init}, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
